// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller: PC, 2-entry fetch buffer, redirect handling
// Optional misaligned-redirect fault: define FETCH_MISALIGN_CHECK_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic        fetch_fault_o
);

  typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_pc_q    [2];
  logic [31:0] buf_instr_q [2];
  logic [1:0]  count_q;
  logic        pop, push, redirect_ok, misalign, wr_idx;

  assign if_valid_o  = (count_q != 2'd0);
  assign if_pc_o     = buf_pc_q[0];
  assign if_instr_o  = buf_instr_q[0];
  assign imem_addr_o = pc_q;
  assign pop         = if_valid_o && if_ready_i;
  assign redirect_ok = redirect_i && (state_q != FAULT);
  // Slot the new word lands in, after any same-cycle pop has shifted the buffer.
  assign wr_idx      = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign      = (redirect_pc_i[1:0] != 2'b00);
  assign fetch_fault_o = (state_q == FAULT);
`else
  assign misalign      = 1'b0;
  assign fetch_fault_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    case (state_q)
      IDLE:    if (fetch_en_i) state_d = FETCH;
      FETCH:   if (!fetch_en_i) state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (redirect_ok) begin
      if (misalign) state_d = FAULT;
      else          pc_d    = redirect_pc_i & 32'hFFFF_FFFC;
    end else if ((state_q == FETCH) && fetch_en_i && ((count_q != 2'd2) || pop)) begin
      push = 1'b1;
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_pc_q[i]    <= 32'd0;
        buf_instr_q[i] <= 32'd0;
      end
    end else if (redirect_ok) begin
      count_q <= 2'd0;
    end else begin
      if (pop) begin
        buf_pc_q[0]    <= buf_pc_q[1];
        buf_instr_q[0] <= buf_instr_q[1];
      end
      if (push) begin
        buf_pc_q[wr_idx]    <= pc_q;
        buf_instr_q[wr_idx] <= imem_instr_i;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller for the single-issue core. It owns the program counter and drives the combinational instruction memory address each cycle. Fetched words go into a 2-entry buffer that feeds decode through a valid/ready handshake. Branch and jump redirects from execute flush the buffer and restart fetch at the new target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `fetch_en_i`  in  1  fetch enable; low holds PC and stops pushes.
- `imem_addr_o`  out  32  byte address to instruction memory; equals the PC register.
- `imem_instr_i`  in  32  instruction word, combinational from `imem_addr_o`, same cycle.
- `redirect_i`  in  1  redirect request from execute.
- `redirect_pc_i`  in  32  redirect target byte address.
- `if_valid_o`  out  1  buffer head holds a valid instruction.
- `if_ready_i`  in  1  decode accepts the head this cycle.
- `if_instr_o`  out  32  head instruction.
- `if_pc_o`  out  32  byte PC of the head instruction.
- `fetch_fault_o`  out  1  sticky misaligned-redirect fault; see Configuration.

## Operation
- State: PC register, 2-entry FIFO of {pc, instr}, 2-bit count (0..2), FSM {IDLE, FETCH, FAULT}.
- FSM transitions:
  - IDLE→FETCH when `fetch_en_i`=1.
  - FETCH→IDLE when `fetch_en_i`=0. The buffer is kept and keeps draining.
  - FETCH/IDLE→FAULT only under the macro.
  - FAULT exits only on reset.
- Pop: `if_valid_o`&&`if_ready_i`.
- Push: in FETCH, with no redirect, when count<2 or a pop occurs in the same cycle.
  - Push writes {PC, `imem_instr_i`}.
  - PC←PC+4, with 32-bit wrap-around; 0xFFFF_FFFC wraps to 0.
- Redirect has priority over everything else and is honoured in IDLE or FETCH:
  - FIFO flushed (count←0); any same-cycle pop is discarded.
  - PC←`redirect_pc_i`.
  - No push that cycle.
- Memory decodes only addr[9:2], so PC 0x400 reads word 0. The controller does not mask the PC: `if_pc_o` reports the full 32-bit value.
- Simultaneous push and pop at count=2: count stays 2 and the entries shift.
- `if_instr_o`/`if_pc_o` are don't-care when `if_valid_o`=0. Benches must not check them then.

## Timing
- Reset values:
  - PC=`RESET_PC`, count=0, state IDLE.
  - `if_valid_o`=0, `if_instr_o`=0, `if_pc_o`=0, `fetch_fault_o`=0, `imem_addr_o`=`RESET_PC`.
- Reset asserted mid-operation clears the buffer and PC immediately, asynchronously. Fetch resumes from `RESET_PC`.
- Latency: the push at edge N makes `if_valid_o`=1 after edge N, i.e. one cycle from PC to decode.
- Redirect at edge N: the first target instruction is pushed at edge N+1 and is valid after N+1. Redirect-to-valid is 2 cycles.
- Throughput: one instruction per cycle when `if_ready_i` is held high.
- Handshake rules:
  - The head is stable while `if_valid_o`=1 and `if_ready_i`=0.
  - `if_valid_o` is never combinationally dependent on `if_ready_i`.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc_i[1:0]`≠0 flushes the FIFO, leaves the PC unchanged, and enters FAULT.
  - In FAULT: `fetch_fault_o`=1 from the next cycle, no pushes, further redirects ignored, until reset.
- Not defined:
  - Redirect target bits [1:0] are forced to 0 (PC←{`redirect_pc_i`[31:2],2'b00}).
  - FAULT is unreachable; `fetch_fault_o` is tied to 0.

## Test plan
- Reset, then `fetch_en_i`=1 and `if_ready_i`=1, memory holding 0x00A02083, 0x01402103, 0x002081B3 at words 0–2 → head (pc, instr) is (0x0, 0x00A02083), (0x4, 0x01402103), (0x8, 0x002081B3) on consecutive cycles.
- `if_ready_i`=0 for 5 cycles → count saturates at 2, PC stops at 0x8, head stays (0x0, 0x00A02083); release ready → 0x0, 0x4, 0x8 delivered with no gap or duplicate.
- With the FIFO full, redirect to 0x40 in the same cycle as a pop → popped entry discarded, `if_valid_o`=0 for one cycle, next head pc=0x40.
- Redirect to 0x3F8 and run → pcs 0x3F8, 0x3FC, 0x400, and the instruction at 0x400 equals the word at 0x0.
- Redirect to 0x42: with macro, `fetch_fault_o`=1 and `if_valid_o`=0 until reset; without macro, head pc=0x40.
- Assert `rst_ni`=0 mid-stream with `RESET_PC`=0x100 → outputs reset immediately; after release, first head pc=0x100.
